// File: rtl/pipe_gap_scheduler.sv
// Pipe-gap scheduler: runs the LFSR source for one sample period, folds the
// sample into the legal gap range, limits the step size and offers it on valid/ready.
module pipe_gap_scheduler #(
  parameter int unsigned GAP_MIN      = 40,
  parameter int unsigned GAP_MAX      = 160,
  parameter int unsigned MAX_STEP     = 40,
  parameter int unsigned GAP_INIT     = 100,
  parameter int unsigned SHIFT_CYCLES = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       game_run,
  input  logic [7:0] rng_value,
  output logic       rng_en,
  output logic [7:0] gap_y,
  output logic       gap_valid,
  input  logic       gap_ready
);

  localparam int unsigned AW = 9;
  localparam int unsigned CW = $clog2(SHIFT_CYCLES + 1);
  localparam logic [AW-1:0] MIN_A  = AW'(GAP_MIN);
  localparam logic [AW-1:0] MAX_A  = AW'(GAP_MAX);
  localparam logic [AW-1:0] STEP_A = AW'(MAX_STEP);
  localparam logic [AW-1:0] INIT_A = AW'(GAP_INIT);
  localparam logic [AW-1:0] SPAN_A = AW'(GAP_MAX - GAP_MIN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SHIFT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SAMPLE, S_WRAP, S_CLAMP, S_HOLD
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [AW-1:0] r_cand, w_cand;
  logic [AW-1:0] r_prev, w_prev;
  logic [7:0]    r_gap_y, w_gap_y;
  logic          r_gap_valid, w_gap_valid;
  logic          r_rng_en, w_rng_en;
  logic [AW-1:0] w_hi, w_lim, w_sat;

  // Step limit relative to the previous gap, then saturate to the legal range
  always_comb begin
    w_hi  = r_prev + STEP_A;
    w_lim = r_cand;
    if (r_cand > w_hi) begin
      w_lim = w_hi;
    end else if ((r_cand + STEP_A) < r_prev) begin
      w_lim = r_prev - STEP_A;
    end
    w_sat = w_lim;
    if (w_lim < MIN_A) begin
      w_sat = MIN_A;
    end else if (w_lim > MAX_A) begin
      w_sat = MAX_A;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_cand      = r_cand;
    w_prev      = r_prev;
    w_gap_y     = r_gap_y;
    w_gap_valid = r_gap_valid;
    w_rng_en    = 1'b0;
    if (!game_run) begin
      // Abort wins over everything, including a same-cycle transfer
      w_state     = S_IDLE;
      w_cnt       = '0;
      w_prev      = INIT_A;
      w_gap_valid = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state  = S_FILL;
          w_cnt    = '0;
          w_rng_en = 1'b1;
        end
        S_FILL: begin
          if (r_cnt == CNT_LAST) begin
            w_state = S_SAMPLE;
            w_cnt   = '0;
          end else begin
            w_cnt    = r_cnt + CW'(1);
            w_rng_en = 1'b1;
          end
        end
        S_SAMPLE: begin
          w_cand  = MIN_A + AW'(rng_value);
          w_state = S_WRAP;
        end
        S_WRAP: begin
          if (r_cand > MAX_A) begin
            w_cand = r_cand - SPAN_A;
          end else begin
            w_state = S_CLAMP;
          end
        end
        S_CLAMP: begin
          w_gap_y     = w_sat[7:0];
          w_prev      = w_sat;
          w_gap_valid = 1'b1;
          w_state     = S_HOLD;
        end
        S_HOLD: begin
          // Prefetch the next gap as soon as this one is taken
          if (r_gap_valid && gap_ready) begin
            w_gap_valid = 1'b0;
            w_state     = S_FILL;
            w_cnt       = '0;
            w_rng_en    = 1'b1;
          end
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cand      <= '0;
      r_prev      <= INIT_A;
      r_gap_y     <= '0;
      r_gap_valid <= 1'b0;
      r_rng_en    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_cand      <= w_cand;
      r_prev      <= w_prev;
      r_gap_y     <= w_gap_y;
      r_gap_valid <= w_gap_valid;
      r_rng_en    <= w_rng_en;
    end
  end

  assign rng_en    = r_rng_en;
  assign gap_y     = r_gap_y;
  assign gap_valid = r_gap_valid;

endmodule

// File: tb/tb_pipe_gap_scheduler.sv
// Directed and randomised checks of pipe_gap_scheduler against hand values and a small model.
module tb_pipe_gap_scheduler;

  localparam int GMIN = 40;
  localparam int GMAX = 160;
  localparam int STEP = 40;
  localparam int SPAN = GMAX - GMIN + 1;

  logic       clock;
  logic       reset;
  logic       game_run;
  logic [7:0] rng_value;
  logic       rng_en;
  logic [7:0] gap_y;
  logic       gap_valid;
  logic       gap_ready;

  int total = 0;
  int bad   = 0;

  pipe_gap_scheduler dut (
    .clock     (clock),
    .reset     (reset),
    .game_run  (game_run),
    .rng_value (rng_value),
    .rng_en    (rng_en),
    .gap_y     (gap_y),
    .gap_valid (gap_valid),
    .gap_ready (gap_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: fold by modulo, then step limit, then saturate
  function automatic int model(input int prev, input int r);
    int c;
    c = GMIN + (r % SPAN);
    if (c > prev + STEP) c = prev + STEP;
    else if (c + STEP < prev) c = prev - STEP;
    if (c < GMIN) c = GMIN;
    if (c > GMAX) c = GMAX;
    return c;
  endfunction

  // Called in the first FILL cycle; returns cycles until gap_valid and rng_en-high count
  task automatic run_to_valid(output int lat, output int en);
    lat = 0;
    en  = 0;
    while (gap_valid !== 1'b1 && lat < 40) begin
      if (rng_en === 1'b1) en++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, en, n, cyc, last, exp_gap, r;
    bit ok, xfer;

    reset     = 1'b0;
    game_run  = 1'b0;
    gap_ready = 1'b0;
    rng_value = 8'd250;
    tick();
    tick();
    check("rst_rng_en", 32'(rng_en), 0);
    check("rst_gap_valid", 32'(gap_valid), 0);
    check("rst_gap_y", 32'(gap_y), 0);

    reset = 1'b1;
    tick();
    check("idle_rng_en", 32'(rng_en), 0);
    game_run = 1'b1;
    tick();
    check("fill_entry_rng_en", 32'(rng_en), 1);
    run_to_valid(lat, en);
    check("g1_latency", 32'(lat), 14);
    check("g1_en_cycles", 32'(en), 9);
    check("g1_gap_y", 32'(gap_y), 60);

    // Stall in HOLD
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gap_valid !== 1'b1 || gap_y !== 8'd60 || rng_en !== 1'b0) ok = 1'b0;
    end
    check("hold_stable", 32'(ok), 1);
    rng_value = 8'd50;
    gap_ready = 1'b1;
    tick();
    gap_ready = 1'b0;
    check("xfer_valid_drop", 32'(gap_valid), 0);
    check("xfer_prefetch_en", 32'(rng_en), 1);
    run_to_valid(lat, en);
    check("g2_latency", 32'(lat), 12);
    check("g2_en_cycles", 32'(en), 9);
    check("g2_gap_y", 32'(gap_y), 90);

    // Abort during the fifth FILL cycle
    gap_ready = 1'b1;
    tick();
    gap_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("midfill_rng_en", 32'(rng_en), 1);
    game_run = 1'b0;
    tick();
    check("abort_fill_rng_en", 32'(rng_en), 0);
    check("abort_fill_valid", 32'(gap_valid), 0);
    game_run  = 1'b1;
    rng_value = 8'd250;
    tick();
    run_to_valid(lat, en);
    check("g3_latency", 32'(lat), 14);
    check("g3_gap_y", 32'(gap_y), 60);

    // Abort in HOLD with a same-cycle ready: transfer must not count
    game_run  = 1'b0;
    gap_ready = 1'b1;
    tick();
    check("abort_hold_valid", 32'(gap_valid), 0);
    check("abort_hold_rng_en", 32'(rng_en), 0);
    game_run  = 1'b1;
    gap_ready = 1'b0;
    rng_value = 8'd200;
    tick();
    run_to_valid(lat, en);
    check("g4_latency", 32'(lat), 13);
    check("g4_gap_y", 32'(gap_y), 119);

    // Random samples with random ready
    exp_gap = 119;
    last    = -1;
    n       = 0;
    cyc     = 0;
    xfer    = 1'b0;
    while (n < 1000 && cyc < 60000) begin
      gap_ready = 1'($urandom_range(0, 1));
      if (gap_valid === 1'b1 && gap_ready === 1'b1) begin
        check("rand_gap_y", 32'(gap_y), 32'(exp_gap));
        check("rand_range", 32'(int'(gap_y) >= GMIN && int'(gap_y) <= GMAX), 1);
        if (last >= 0) begin
          check("rand_step", 32'((int'(gap_y) - last <= STEP) && (last - int'(gap_y) <= STEP)), 1);
        end
        last      = int'(gap_y);
        n++;
        r         = int'($urandom_range(0, 255));
        rng_value = 8'(r);
        exp_gap   = model(exp_gap, r);
        xfer      = 1'b1;
      end
      tick();
      cyc++;
      if (xfer) begin
        check("rand_valid_drop", 32'(gap_valid), 0);
        xfer = 1'b0;
      end
    end
    check("rand_gap_count", 32'(n), 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_gap_scheduler.md
Name: pipe_gap_scheduler

Overview:
Sequences the 8-bit LFSR random source and turns its samples into playable pipe-gap heights for the pipe spawner.
- Drives the source's enable for exactly one full sample period, then captures the fresh value.
- Folds the value into [GAP_MIN, GAP_MAX] and limits the jump from the previous gap to ±MAX_STEP.
- Presents the result on a valid/ready handshake.
- Prefetches one gap ahead, so a spawn never waits on the RNG.

Parameters:
GAP_MIN, 40, lowest legal gap centre (pixel row), < GAP_MAX
GAP_MAX, 160, highest legal gap centre, ≤ 255
MAX_STEP, 40, max |gap_y(n) − gap_y(n−1)|
GAP_INIT, 100, previous-gap value after reset/abort, within [GAP_MIN, GAP_MAX]
SHIFT_CYCLES, 9, enabled cycles needed for the source to publish a new sample

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low; 0 = reset
game_run  in  1  1 = game active; 0 aborts any operation
rng_value  in  8  current output of the random source
rng_en  out  1  enable to the random source
gap_y  out  8  gap centre, valid only while gap_valid=1
gap_valid  out  1  gap_y holds a finished value
gap_ready  in  1  spawner accepts gap_y; transfer = gap_valid & gap_ready on a clock edge

Behaviour:
Reset values (reset=0, asynchronous):
- state=IDLE, rng_en=0, gap_valid=0, gap_y=0, prev=GAP_INIT, shift counter=0.

Internal arithmetic:
- 9-bit unsigned; SPAN = GAP_MAX−GAP_MIN+1.

States:
- IDLE: rng_en=0. If game_run=1, go to FILL with counter=0.
- FILL: rng_en=1; counter increments each cycle. After SHIFT_CYCLES cycles in FILL (counter reaches SHIFT_CYCLES−1), go to SAMPLE. rng_en is 1 for exactly SHIFT_CYCLES consecutive cycles per gap.
- SAMPLE: rng_en=0; cand = GAP_MIN + rng_value. Go to WRAP.
- WRAP: if cand > GAP_MAX, cand = cand − SPAN and stay in WRAP; else go to CLAMP. One subtraction per cycle; defaults need ≤2.
- CLAMP:
  - if cand > prev+MAX_STEP, cand = prev+MAX_STEP;
  - else if cand+MAX_STEP < prev, cand = prev−MAX_STEP;
  - then saturate cand to [GAP_MIN, GAP_MAX];
  - register gap_y=cand, prev=cand, gap_valid=1; go to HOLD.
- HOLD: gap_y and gap_valid stable until transfer. On transfer: gap_valid=0 next cycle, go to FILL (prefetch the next gap). gap_ready while gap_valid=0 is ignored.

Latency:
- FILL entry to gap_valid=1 = SHIFT_CYCLES + 1 + (WRAP cycles, minimum 1) + 1 clocks.
- With defaults: 12 cycles when no wrap subtraction is needed, up to 14.

Abort:
- game_run=0 in any state: next edge forces IDLE, rng_en=0, gap_valid=0, prev=GAP_INIT, counter=0.
- A pending unaccepted gap is discarded.
- game_run=0 takes priority over a same-cycle transfer; the transfer is not counted.

Back-to-back:
- gap_ready held high gives one gap per (latency+1) cycles. No gap is duplicated or skipped.

Mid-FILL reset:
- Asynchronous return to reset values. The source is reset by the same line.

Test Plan:
- Reset, then game_run=1 -> rng_en high exactly 9 consecutive cycles, gap_valid rises on the 12th or later cycle after FILL entry; all outputs 0 during reset.
- prev=100 (reset), rng_value=250 at SAMPLE -> cand 290→169→48 (two WRAP cycles), clamp to 100−40 -> gap_y=60, valid 14 cycles after FILL entry.
- Next gap with rng_value=50 -> cand 90, |90−60|≤40 -> gap_y=90, no wrap.
- gap_ready=0 for 20 cycles in HOLD -> gap_y/gap_valid stable, rng_en=0; gap_ready=1 one cycle -> gap_valid=0 next cycle and rng_en=1 (prefetch starts).
- game_run dropped mid-FILL (cycle 5) and again in HOLD with gap_ready=1 same cycle -> IDLE, rng_en=0, gap_valid=0; restart yields clamp relative to prev=100.
- Randomised rng_value over 1000 gaps with random gap_ready -> every gap_y in [40,160], every step ≤40, no lost or repeated handshakes.
